// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one 4-bit ALU between two requesters, with registered ALU drive and result capture.
// Optional divide-by-zero flagging is enabled with the macro ALU_SCHED_DIVZERO_CHK_EN.
module alu_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req0_sel,
    input  logic [3:0] req1_sel,
    input  logic [3:0] req0_a,
    input  logic [3:0] req1_a,
    input  logic [3:0] req0_b,
    input  logic [3:0] req1_b,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [3:0] alu_out,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_data,
    output logic       rsp_carry,
    output logic       rsp_err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_next;
    logic   last;
    logic   grant;
    logic   accept;
    logic   div_zero;

    always_comb begin
        grant = req_valid[1];
        if (req_valid == 2'b11) begin
            grant = ~last;
        end
    end

    // req_ready is gated by rst_n so it reads 2'b00 while reset is held
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && rst_n && req_valid[grant]) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
    end

    assign accept    = |(req_valid & req_ready);
    assign rsp_valid = (state == RESP);

`ifdef ALU_SCHED_DIVZERO_CHK_EN
    assign div_zero = (alu_sel == 4'b0011) && (alu_b == 4'h0);
`else
    assign div_zero = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last    <= 1'b1;
            alu_a   <= 4'h0;
            alu_b   <= 4'h0;
            alu_sel <= 4'h0;
            rsp_id  <= 1'b0;
        end else if (accept) begin
            last    <= grant;
            alu_a   <= grant ? req1_a : req0_a;
            alu_b   <= grant ? req1_b : req0_b;
            alu_sel <= grant ? req1_sel : req0_sel;
            rsp_id  <= grant;
        end
    end

    // Result capture happens once, at the end of EXEC, and is then held through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= 4'h0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data  <= div_zero ? 4'hF : alu_out;
            rsp_carry <= alu_carry;
            rsp_err   <= div_zero;
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: a behavioural ALU model closes the loop, directed vectors push expected responses.
module tb_alu_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [3:0] req0_sel = 4'h0, req1_sel = 4'h0;
    logic [3:0] req0_a = 4'h0, req1_a = 4'h0;
    logic [3:0] req0_b = 4'h0, req1_b = 4'h0;
    logic [3:0] alu_a, alu_b, alu_sel;
    logic [3:0] alu_out;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_id;
    logic [3:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_err;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];

    alu_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_sel(req0_sel), .req1_sel(req1_sel),
        .req0_a(req0_a), .req1_a(req1_a),
        .req0_b(req0_b), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: add, sub, divide (0 on b==0), and, or, xor otherwise; carry is always from a+b
    always_comb begin
        logic [4:0] sum;
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = sum[4];
        case (alu_sel)
            4'b0000: alu_out = sum[3:0];
            4'b0001: alu_out = alu_a - alu_b;
            4'b0011: alu_out = (alu_b == 4'h0) ? 4'h0 : alu_a / alu_b;
            4'b1000: alu_out = alu_a & alu_b;
            4'b1001: alu_out = alu_a | alu_b;
            default: alu_out = alu_a ^ alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] pack(input logic id, input logic [3:0] data, input logic carry, input logic err);
        return {id, data, carry, err};
    endfunction

    // Monitor: every response handshake pops one expected entry, in issue order
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", {25'd0, rsp_id, rsp_data, rsp_carry, rsp_err}, 32'h7F00);
            end else begin
                check("rsp_fields", {25'd0, rsp_id, rsp_data, rsp_carry, rsp_err}, {25'd0, exp_q.pop_front()});
            end
        end
    end

    // Waits for a request handshake and returns just after the accepting edge
    task automatic applyStimulus();
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                seen = 1;
                break;
            end
        end
        check("accept_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name);
        check({name, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({name, "_req_ready"}, {30'd0, req_ready}, 32'd0);
        check({name, "_alu_a"}, {28'd0, alu_a}, 32'd0);
        check({name, "_alu_b"}, {28'd0, alu_b}, 32'd0);
        check({name, "_alu_sel"}, {28'd0, alu_sel}, 32'd0);
        check({name, "_rsp_fields"}, {25'd0, rsp_id, rsp_data, rsp_carry, rsp_err}, 32'd0);
    endtask

    initial begin
        req_valid = 2'b11;
        #3;
        checkOutput("reset");
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Contention: req0 AND C&A=8 (carry 1), req1 OR 3|4=7 (carry 0), alternating
        req0_sel = 4'b1000; req0_a = 4'hC; req0_b = 4'hA;
        req1_sel = 4'b1001; req1_a = 4'h3; req1_b = 4'h4;
        req_valid = 2'b11;
        #1;
        check("contend_first_grant", {30'd0, req_ready}, 32'h1);
        exp_q.push_back(pack(1'b0, 4'h8, 1'b1, 1'b0));
        exp_q.push_back(pack(1'b1, 4'h7, 1'b0, 1'b0));
        exp_q.push_back(pack(1'b0, 4'h8, 1'b1, 1'b0));
        exp_q.push_back(pack(1'b1, 4'h7, 1'b0, 1'b0));
        for (int n = 0; n < 4; n++) applyStimulus();
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        // Single request: 9+8 wraps to 1 with carry
        req0_sel = 4'b0000; req0_a = 4'h9; req0_b = 4'h8;
        req_valid = 2'b01;
        #1;
        check("single_req_ready", {30'd0, req_ready}, 32'h1);
        exp_q.push_back(pack(1'b0, 4'h1, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        check("single_exec_valid", {31'd0, rsp_valid}, 32'd0);
        check("single_alu_drive", {20'd0, alu_sel, alu_a, alu_b}, 32'h098);
        @(posedge clk);
        #1;
        check("single_resp_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Backpressure: req1 SUB 5-3=2, carry of 5+3 is 0
        rsp_ready = 1'b0;
        req1_sel = 4'b0001; req1_a = 4'h5; req1_b = 4'h3;
        req_valid = 2'b10;
        exp_q.push_back(pack(1'b1, 4'h2, 1'b0, 1'b0));
        applyStimulus();
        req_valid = 2'b11;
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_fields", {25'd0, rsp_id, rsp_data, rsp_carry, rsp_err}, {25'd0, pack(1'b1, 4'h2, 1'b0, 1'b0)});
            check("bp_req_ready", {30'd0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_release_ready", {30'd0, req_ready}, 32'h1);
        req_valid = 2'b00;
        @(posedge clk);
        #1;

        // Divide by zero: 7/0, carry of 7+0 is 0
        req0_sel = 4'b0011; req0_a = 4'h7; req0_b = 4'h0;
        req_valid = 2'b01;
`ifdef ALU_SCHED_DIVZERO_CHK_EN
        exp_q.push_back(pack(1'b0, 4'hF, 1'b0, 1'b1));
`else
        exp_q.push_back(pack(1'b0, 4'h0, 1'b0, 1'b0));
`endif
        applyStimulus();
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // Reset during EXEC discards the operation
        req0_sel = 4'b0000; req0_a = 4'h1; req0_b = 4'h1;
        req_valid = 2'b01;
        applyStimulus();
        rst_n = 1'b0;
        #1;
        checkOutput("midreset");
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Pointer restored: requester 0 wins, 2+3=5
        req0_sel = 4'b0000; req0_a = 4'h2; req0_b = 4'h3;
        req1_sel = 4'b0000; req1_a = 4'h1; req1_b = 4'h1;
        req_valid = 2'b11;
        #1;
        check("post_reset_grant", {30'd0, req_ready}, 32'h1);
        exp_q.push_back(pack(1'b0, 4'h5, 1'b0, 1'b0));
        applyStimulus();
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-port scheduler that shares one combinational 4-bit ALU between two requesters. It owns the ALU input lines (A, B, Sel), arbitrates round-robin, and registers the ALU output (result and carry). It returns each result with a requester ID over a valid/ready response channel. It sits between the instruction-issue logic and the ALU in the 4-bit CPU datapath.

## Interface
Parameters:
- none; all widths are fixed at 4 bits to match the ALU.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  2  per-requester request valid; bit i = requester i
- req_ready  output  2  per-requester accept; one-hot or zero
- req0_sel, req1_sel  input  4 each  ALU opcode per requester (ALU Sel encoding)
- req0_a, req1_a  input  4 each  operand A per requester
- req0_b, req1_b  input  4 each  operand B per requester
- alu_a, alu_b, alu_sel  output  4 each  registered drive to the ALU inputs
- alu_out  input  4  ALU result
- alu_carry  input  1  ALU CarryOut (carry of A+B, independent of Sel)
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_id  output  1  requester that issued this result
- rsp_data  output  4  captured ALU result
- rsp_carry  output  1  captured ALU carry
- rsp_err  output  1  divide-by-zero flag; see Configuration

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - grant = the requester with valid set; if both are valid, the one not served last.
  - req_ready[grant] = 1 only in IDLE (combinational from state and req_valid).
  - On handshake (valid & ready): latch grant's sel/a/b into alu_sel/alu_a/alu_b, latch rsp_id = grant, update last-served pointer, go to EXEC.
- EXEC: the ALU settles from the registered inputs. At the end of the cycle, capture alu_out into rsp_data and alu_carry into rsp_carry, compute rsp_err, and go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id/rsp_data/rsp_carry/rsp_err are held stable.
  - On rsp_ready, go to IDLE.
  - No request is accepted in RESP, even when rsp_ready is high.
- Last-served pointer resets to 1, so requester 0 wins the first simultaneous contention.
- The arbitration is single-outstanding: it never has more than one operation in flight.
- Requesters must hold valid and payload stable until ready; dropping valid before ready is legal and is treated as no request.
- alu_a/alu_b/alu_sel keep their last value outside EXEC; they change only on an accept.
- Reset asserted in any state returns to IDLE immediately. The in-flight operation is discarded and produces no response.

## Timing
- Reset values:
  - req_ready = 2'b00
  - alu_a = alu_b = alu_sel = 4'h0
  - rsp_valid = 0, rsp_id = 0, rsp_data = 4'h0, rsp_carry = 0, rsp_err = 0
  - state IDLE, pointer 1
- Latency: accept at edge N → ALU inputs valid after N → result captured at N+1 → rsp_valid high from N+1 until the edge where rsp_ready = 1.
- Minimum issue interval is 3 cycles (IDLE, EXEC, RESP with rsp_ready already high).
- rsp_valid deasserts the cycle after the response handshake. req_ready may assert in that same cycle.
- Arithmetic is the ALU's: 4-bit wrap, no sign handling in this block.

## Configuration
- Macro: ALU_SCHED_DIVZERO_CHK_EN.
- Defined:
  - In EXEC, if alu_sel == 4'b0011 and alu_b == 4'h0, capture rsp_data = 4'hF and rsp_err = 1, ignoring alu_out.
  - All other cases set rsp_err = 0.
- Undefined:
  - rsp_data always equals alu_out, whatever the ALU produces for divide by zero.
  - rsp_err is tied to 0.

## Test plan
- Single request: req0 valid with sel=0000, a=4'h9, b=4'h8.
  - req_ready[0] the same cycle.
  - Two cycles later: rsp_valid=1, rsp_data=4'h1, rsp_carry=1, rsp_id=0.
- Contention: both valid, req0 sel=1000 a=C b=A; req1 sel=1001 a=3 b=4.
  - Order: req0 first (rsp_data=8), then req1 (rsp_data=7, rsp_id=1).
  - Then alternation continues while both remain valid.
- Backpressure: hold rsp_ready=0 for 5 cycles.
  - rsp_valid and all rsp_* fields stay stable.
  - req_ready stays 2'b00.
  - Release → IDLE next cycle.
- Divide by zero: sel=0011, a=7, b=0.
  - With macro defined: rsp_data=F, rsp_err=1.
  - Without macro: rsp_data equals the ALU output, rsp_err=0.
- Reset mid-operation: assert rst_n=0 in EXEC.
  - All outputs take reset values asynchronously.
  - No response is emitted after release.
  - Next simultaneous request is granted to requester 0.
